// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared screen geometry, colours and FSM encoding for the pong rectangle drawer
package pong_pkg;

  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_WHITE = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAW  = 2'd1,
    EMPTY = 2'd2
  } state_t;

endpackage

// File: rtl/pong_raster_counter.sv
// rtl/pong_raster_counter.sv - nested column/row walker producing absolute pixel coordinates in raster order
module pong_raster_counter
  import pong_pkg::*;
(
  input  logic           clock,
  input  logic           resetn,
  input  logic           load,
  input  logic           step,
  input  logic [X_W-1:0] x0,
  input  logic [Y_W-1:0] y0,
  input  logic [X_W-1:0] w,
  input  logic [Y_W-1:0] h,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);

  logic [X_W-1:0] x_q, x_d, x0_q, x0_d, w_q, w_d, xcnt_q, xcnt_d;
  logic [Y_W-1:0] y_q, y_d, ycnt_q, ycnt_d;

  // xcnt/ycnt count remaining columns/rows minus one; coordinates wrap at their natural width
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    x0_d   = x0_q;
    w_d    = w_q;
    xcnt_d = xcnt_q;
    ycnt_d = ycnt_q;
    if (load) begin
      x_d    = x0;
      y_d    = y0;
      x0_d   = x0;
      w_d    = w;
      xcnt_d = w - 1'b1;
      ycnt_d = h - 1'b1;
    end else if (step) begin
      if (xcnt_q == '0) begin
        x_d    = x0_q;
        xcnt_d = w_q - 1'b1;
        y_d    = y_q + 1'b1;
        ycnt_d = ycnt_q - 1'b1;
      end else begin
        x_d    = x_q + 1'b1;
        xcnt_d = xcnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      x_q    <= '0;
      y_q    <= '0;
      x0_q   <= '0;
      w_q    <= '0;
      xcnt_q <= '0;
      ycnt_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      x0_q   <= x0_d;
      w_q    <= w_d;
      xcnt_q <= xcnt_d;
      ycnt_q <= ycnt_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = (xcnt_q == '0) && (ycnt_q == '0);

endmodule

// File: rtl/pong_rect_drawer.sv
// rtl/pong_rect_drawer.sv - one-pixel-per-clock rectangle fill engine feeding vga_adapter; PONG_RECT_CLIP_EN enables screen clipping
module pong_rect_drawer
  import pong_pkg::*;
(
  input  logic           clock,
  input  logic           resetn,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [X_W-1:0] req_x,
  input  logic [Y_W-1:0] req_y,
  input  logic [X_W-1:0] req_w,
  input  logic [Y_W-1:0] req_h,
  input  logic [2:0]     req_colour,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [2:0]     colour,
  output logic           plot,
  output logic           done
);

  state_t         state_q, state_d;
  logic           plot_q, plot_d, done_q, done_d;
  logic [2:0]     colour_q, colour_d;
  logic           accept, load, step, last;
  logic [X_W-1:0] w_eff;
  logic [Y_W-1:0] h_eff;

`ifdef PONG_RECT_CLIP_EN
  logic [X_W-1:0] x_room;
  logic [Y_W-1:0] y_room;

  // Origins off-screen collapse to zero size so they take the EMPTY path
  always_comb begin
    x_room = X_W'(SCREEN_W) - req_x;
    y_room = Y_W'(SCREEN_H) - req_y;
    if (req_x >= X_W'(SCREEN_W))  w_eff = '0;
    else if (req_w > x_room)      w_eff = x_room;
    else                          w_eff = req_w;
    if (req_y >= Y_W'(SCREEN_H))  h_eff = '0;
    else if (req_h > y_room)      h_eff = y_room;
    else                          h_eff = req_h;
  end
`else
  assign w_eff = req_w;
  assign h_eff = req_h;
`endif

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d  = state_q;
    plot_d   = 1'b0;
    done_d   = 1'b0;
    colour_d = colour_q;
    load     = 1'b0;
    step     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (w_eff == '0 || h_eff == '0) begin
            state_d = EMPTY;
          end else begin
            state_d  = DRAW;
            plot_d   = 1'b1;
            load     = 1'b1;
            colour_d = req_colour;
          end
        end
      end
      DRAW: begin
        if (last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          plot_d = 1'b1;
          step   = 1'b1;
        end
      end
      EMPTY: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      plot_q   <= 1'b0;
      done_q   <= 1'b0;
      colour_q <= COL_BLACK;
    end else begin
      state_q  <= state_d;
      plot_q   <= plot_d;
      done_q   <= done_d;
      colour_q <= colour_d;
    end
  end

  pong_raster_counter u_counter (
    .clock  (clock),
    .resetn (resetn),
    .load   (load),
    .step   (step),
    .x0     (req_x),
    .y0     (req_y),
    .w      (w_eff),
    .h      (h_eff),
    .x      (x),
    .y      (y),
    .last   (last)
  );

  assign colour = colour_q;
  assign plot   = plot_q;
  assign done   = done_q;

endmodule

// File: tb/tb_pong_rect_drawer.sv
// tb/tb_pong_rect_drawer.sv - directed self-checking bench for pong_rect_drawer
module tb_pong_rect_drawer;
  import pong_pkg::*;

  logic           clock = 1'b0;
  logic           resetn = 1'b0;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [X_W-1:0] req_x = '0;
  logic [Y_W-1:0] req_y = '0;
  logic [X_W-1:0] req_w = '0;
  logic [Y_W-1:0] req_h = '0;
  logic [2:0]     req_colour = '0;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [2:0]     colour;
  logic           plot;
  logic           done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  pong_rect_drawer dut (
    .clock      (clock),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_w      (req_w),
    .req_h      (req_h),
    .req_colour (req_colour),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic [7:0] x0, input logic [6:0] y0,
                           input logic [7:0] w, input logic [6:0] h, input logic [2:0] c);
    req_valid  = 1'b1;
    req_x      = x0;
    req_y      = y0;
    req_w      = w;
    req_h      = h;
    req_colour = c;
  endtask

  // Expects a request accepted at the coming edge; checks every pixel then the done cycle.
  task automatic expect_rect(input string tag, input logic [7:0] x0, input logic [6:0] y0,
                             input int ew, input int eh, input logic [2:0] c, input bit chain,
                             input logic [7:0] nx, input logic [6:0] ny, input logic [7:0] nw,
                             input logic [6:0] nh, input logic [2:0] nc);
    logic [7:0] ex;
    logic [6:0] ey;
    ex = x0;
    ey = y0;
    for (int dy = 0; dy < eh; dy++) begin
      for (int dx = 0; dx < ew; dx++) begin
        @(negedge clock);
        ex = x0 + 8'(dx);
        ey = y0 + 7'(dy);
        chk({tag, " plot"}, plot, 1);
        chk({tag, " x"}, x, ex);
        chk({tag, " y"}, y, ey);
        chk({tag, " colour"}, colour, c);
        chk({tag, " ready"}, req_ready, 0);
        chk({tag, " done"}, done, 0);
        if (dx == 0 && dy == 0) begin
          if (chain) begin
            drive_req(nx, ny, nw, nh, nc);
          end else begin
            req_valid  = 1'b0;
            req_x      = 8'($urandom);
            req_y      = 7'($urandom);
            req_w      = 8'($urandom);
            req_h      = 7'($urandom);
            req_colour = 3'($urandom);
          end
        end
      end
    end
    @(negedge clock);
    chk({tag, " end plot"}, plot, 0);
    chk({tag, " end done"}, done, 1);
    chk({tag, " end ready"}, req_ready, 1);
    chk({tag, " end x hold"}, x, ex);
    chk({tag, " end y hold"}, y, ey);
    chk({tag, " end colour hold"}, colour, c);
  endtask

  task automatic expect_empty(input string tag, input logic [2:0] old_c);
    @(negedge clock);
    req_valid = 1'b0;
    chk({tag, " c1 ready"}, req_ready, 0);
    chk({tag, " c1 plot"}, plot, 0);
    chk({tag, " c1 done"}, done, 0);
    @(negedge clock);
    chk({tag, " c2 done"}, done, 1);
    chk({tag, " c2 ready"}, req_ready, 1);
    chk({tag, " c2 plot"}, plot, 0);
    chk({tag, " c2 colour hold"}, colour, old_c);
    @(negedge clock);
    chk({tag, " c3 done"}, done, 0);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("reset plot", plot, 0);
    chk("reset ready", req_ready, 1);
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("idle plot", plot, 0);
      chk("idle done", done, 0);
      chk("idle ready", req_ready, 1);
    end
    chk("idle x", x, 0);
    chk("idle y", y, 0);
    chk("idle colour", colour, 0);

    // 2x3 white at (10,20)
    drive_req(8'd10, 7'd20, 8'd2, 7'd3, COL_WHITE);
    expect_rect("rect2x3", 8'd10, 7'd20, 2, 3, COL_WHITE, 1'b0, '0, '0, '0, '0, '0);
    @(negedge clock);
    chk("rect2x3 done drop", done, 0);

    drive_req(8'd40, 7'd40, 8'd0, 7'd5, COL_BLACK);
    expect_empty("empty w0", COL_WHITE);

    // Second request held valid while busy; accepted in the done cycle
    drive_req(8'd30, 7'd40, 8'd3, 7'd2, COL_WHITE);
    expect_rect("b2b first", 8'd30, 7'd40, 3, 2, COL_WHITE, 1'b1, 8'd50, 7'd60, 8'd1, 7'd2, 3'b010);
    expect_rect("b2b second", 8'd50, 7'd60, 1, 2, 3'b010, 1'b0, '0, '0, '0, '0, '0);
    @(negedge clock);
    chk("b2b done drop", done, 0);

    drive_req(8'd158, 7'd118, 8'd4, 7'd4, COL_WHITE);
`ifdef PONG_RECT_CLIP_EN
    expect_rect("edge clip", 8'd158, 7'd118, 2, 2, COL_WHITE, 1'b0, '0, '0, '0, '0, '0);
`else
    expect_rect("edge noclip", 8'd158, 7'd118, 4, 4, COL_WHITE, 1'b0, '0, '0, '0, '0, '0);
`endif
    @(negedge clock);

    drive_req(8'd254, 7'd126, 8'd3, 7'd3, 3'b101);
`ifdef PONG_RECT_CLIP_EN
    expect_empty("offscreen clip", COL_WHITE);
`else
    expect_rect("wrap", 8'd254, 7'd126, 3, 3, 3'b101, 1'b0, '0, '0, '0, '0, '0);
    @(negedge clock);
`endif

    // Reset during the third pixel of a 4x4
    drive_req(8'd5, 7'd5, 8'd4, 7'd4, COL_WHITE);
    @(negedge clock);
    req_valid = 1'b0;
    chk("rst pix1 x", x, 5);
    @(negedge clock);
    @(negedge clock);
    chk("rst pix3 plot", plot, 1);
    chk("rst pix3 x", x, 7);
    resetn = 1'b0;
    #1;
    chk("rst async plot", plot, 0);
    chk("rst async ready", req_ready, 1);
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("post rst plot", plot, 0);
      chk("post rst done", done, 0);
      chk("post rst ready", req_ready, 1);
    end

    drive_req(8'd1, 7'd2, 8'd1, 7'd1, COL_WHITE);
    expect_rect("post rst rect", 8'd1, 7'd2, 1, 1, COL_WHITE, 1'b0, '0, '0, '0, '0, '0);
    @(negedge clock);
    chk("post rst done drop", done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
